// File: rtl/control_fsm.sv
// control_fsm: multi-cycle (IF/ID/EX/MEM/WB) control unit for an RV32I subset.
// Every instruction takes five cycles. The instruction word is captured into IR
// on IF->ID, and the Zero flag is captured into a taken flag on EX->MEM. The
// control outputs are decoded only from registered state (state, IR, taken),
// so reset clears them immediately.
//
// Ports:
//   clk       rising-edge clock
//   rst       asynchronous active-low reset
//   instr     instruction word, valid during IF
//   Zero      ALU zero flag, sampled at the end of EX
//   PCSrc     1 = branch target, 0 = PC + 4 (WB only)
//   ALUSrc    1 = immediate operand, 0 = rs2
//   RegWrite  register file write enable (WB only)
//   MemToReg  1 = write back from data memory (lw)
//   ALUCtrl   ALU operation select
//   loadPC    PC update strobe (every WB)
//   MemRead   data memory read strobe (MEM, lw)
//   MemWrite  data memory write strobe (MEM, sw)
//   illegal   unsupported instruction flag (WB only)
//   instret   retired instruction count, wraps
module control_fsm #(
    parameter int unsigned CNT_WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [31:0]          instr,
    input  logic                 Zero,
    output logic                 PCSrc,
    output logic                 ALUSrc,
    output logic                 RegWrite,
    output logic                 MemToReg,
    output logic [3:0]           ALUCtrl,
    output logic                 loadPC,
    output logic                 MemRead,
    output logic                 MemWrite,
    output logic                 illegal,
    output logic [CNT_WIDTH-1:0] instret
);

    localparam logic [2:0] S_IF  = 3'd0;
    localparam logic [2:0] S_ID  = 3'd1;
    localparam logic [2:0] S_EX  = 3'd2;
    localparam logic [2:0] S_MEM = 3'd3;
    localparam logic [2:0] S_WB  = 3'd4;

    localparam logic [6:0] OP_R   = 7'b0110011;
    localparam logic [6:0] OP_I   = 7'b0010011;
    localparam logic [6:0] OP_LW  = 7'b0000011;
    localparam logic [6:0] OP_SW  = 7'b0100011;
    localparam logic [6:0] OP_BEQ = 7'b1100011;

    localparam logic [6:0] F7_BASE = 7'b0000000;
    localparam logic [6:0] F7_ALT  = 7'b0100000;

    localparam logic [3:0] ALU_AND  = 4'b0000;
    localparam logic [3:0] ALU_OR   = 4'b0001;
    localparam logic [3:0] ALU_ADD  = 4'b0010;
    localparam logic [3:0] ALU_SUB  = 4'b0110;
    localparam logic [3:0] ALU_SLT  = 4'b0111;
    localparam logic [3:0] ALU_SRL  = 4'b1000;
    localparam logic [3:0] ALU_SLL  = 4'b1001;
    localparam logic [3:0] ALU_SRA  = 4'b1010;
    localparam logic [3:0] ALU_SLTU = 4'b1011;
    localparam logic [3:0] ALU_XOR  = 4'b1101;

    logic [2:0]  state;
    logic [2:0]  state_next;
    logic [31:0] ir;
    logic        taken;

    logic [6:0] opcode;
    logic [2:0] funct3;
    logic [6:0] funct7;
    logic       shift_f7_ok;

    logic [3:0] dec_alu;
    logic       dec_alusrc;
    logic       is_alu;
    logic       is_lw;
    logic       is_sw;
    logic       is_beq;
    logic       dec_illegal;

    // Operand/register fields belong to the datapath; only the decode fields are used here.
    logic ir_unused;
    assign ir_unused = ^{ir[24:15], ir[11:7]};

    assign opcode      = ir[6:0];
    assign funct3      = ir[14:12];
    assign funct7      = ir[31:25];
    assign shift_f7_ok = (funct7 == F7_BASE) || (funct7 == F7_ALT);

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= S_IF;
        end else begin
            state <= state_next;
        end
    end

    // Fixed five-step sequence; unused encodings recover to IF.
    always_comb begin
        state_next = S_IF;
        case (state)
            S_IF:    state_next = S_ID;
            S_ID:    state_next = S_EX;
            S_EX:    state_next = S_MEM;
            S_MEM:   state_next = S_WB;
            S_WB:    state_next = S_IF;
            default: state_next = S_IF;
        endcase
    end

    // IR capture, branch-taken capture and retired-instruction counter.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ir      <= '0;
            taken   <= 1'b0;
            instret <= '0;
        end else begin
            if (state == S_IF) begin
                ir <= instr;
            end
            if (state == S_EX) begin
                taken <= is_beq & Zero;
            end
            if (state == S_WB) begin
                instret <= instret + CNT_WIDTH'(1);
            end
        end
    end

    // Instruction decode from IR.
    always_comb begin
        dec_alu     = ALU_AND;
        dec_alusrc  = 1'b0;
        is_alu      = 1'b0;
        is_lw       = 1'b0;
        is_sw       = 1'b0;
        is_beq      = 1'b0;
        dec_illegal = 1'b0;
        case (opcode)
            OP_R: begin
                is_alu = 1'b1;
                case (funct7)
                    F7_BASE: begin
                        case (funct3)
                            3'b000:  dec_alu = ALU_ADD;
                            3'b001:  dec_alu = ALU_SLL;
                            3'b010:  dec_alu = ALU_SLT;
                            3'b011:  dec_alu = ALU_SLTU;
                            3'b100:  dec_alu = ALU_XOR;
                            3'b101:  dec_alu = ALU_SRL;
                            3'b110:  dec_alu = ALU_OR;
                            default: dec_alu = ALU_AND;
                        endcase
                    end
                    F7_ALT: begin
                        case (funct3)
                            3'b000:  dec_alu = ALU_SUB;
                            3'b101:  dec_alu = ALU_SRA;
                            default: dec_illegal = 1'b1;
                        endcase
                    end
                    default: dec_illegal = 1'b1;
                endcase
            end
            OP_I: begin
                is_alu     = 1'b1;
                dec_alusrc = 1'b1;
                case (funct3)
                    3'b000:  dec_alu = ALU_ADD;
                    3'b010:  dec_alu = ALU_SLT;
                    3'b011:  dec_alu = ALU_SLTU;
                    3'b100:  dec_alu = ALU_XOR;
                    3'b110:  dec_alu = ALU_OR;
                    3'b001: begin
                        dec_alu     = ALU_SLL;
                        dec_illegal = ~shift_f7_ok;
                    end
                    3'b101: begin
                        // IR[30] picks arithmetic vs logical right shift.
                        dec_alu     = ir[30] ? ALU_SRA : ALU_SRL;
                        dec_illegal = ~shift_f7_ok;
                    end
                    default: dec_alu = ALU_AND;
                endcase
            end
            OP_LW: begin
                is_lw       = 1'b1;
                dec_alusrc  = 1'b1;
                dec_alu     = ALU_ADD;
                dec_illegal = (funct3 != 3'b010);
            end
            OP_SW: begin
                is_sw       = 1'b1;
                dec_alusrc  = 1'b1;
                dec_alu     = ALU_ADD;
                dec_illegal = (funct3 != 3'b010);
            end
            OP_BEQ: begin
                is_beq      = 1'b1;
                dec_alu     = ALU_SUB;
                dec_illegal = (funct3 != 3'b000);
            end
            default: dec_illegal = 1'b1;
        endcase
        // Unsupported encodings execute as a NOP with every effect suppressed.
        if (dec_illegal) begin
            dec_alu    = ALU_AND;
            dec_alusrc = 1'b0;
            is_alu     = 1'b0;
            is_lw      = 1'b0;
            is_sw      = 1'b0;
            is_beq     = 1'b0;
        end
    end

    // Control outputs: decoded fields held from ID to WB, strobes in their own state.
    always_comb begin
        PCSrc    = 1'b0;
        ALUSrc   = 1'b0;
        RegWrite = 1'b0;
        MemToReg = 1'b0;
        ALUCtrl  = 4'b0000;
        loadPC   = 1'b0;
        MemRead  = 1'b0;
        MemWrite = 1'b0;
        illegal  = 1'b0;
        if (state != S_IF) begin
            ALUCtrl  = dec_alu;
            ALUSrc   = dec_alusrc;
            MemToReg = is_lw;
        end
        case (state)
            S_MEM: begin
                MemRead  = is_lw;
                MemWrite = is_sw;
            end
            S_WB: begin
                RegWrite = is_alu | is_lw;
                loadPC   = 1'b1;
                PCSrc    = taken;
                illegal  = dec_illegal;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_control_fsm.sv
// tb_control_fsm: randomized and directed checks of control_fsm against a
// per-instruction reference model (decode table + per-step output rules).
module tb_control_fsm;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [31:0] instr = 32'h0;
    logic        Zero = 1'b0;

    logic        PCSrc, ALUSrc, RegWrite, MemToReg, loadPC, MemRead, MemWrite, illegal;
    logic [3:0]  ALUCtrl;
    logic [31:0] instret;

    logic        w_PCSrc, w_ALUSrc, w_RegWrite, w_MemToReg, w_loadPC, w_MemRead, w_MemWrite, w_illegal;
    logic [3:0]  w_ALUCtrl;
    logic [2:0]  instret_w;

    int          checks = 0;
    int          errors = 0;
    int unsigned model_cnt = 0;

    control_fsm #(.CNT_WIDTH(32)) dut (
        .clk(clk), .rst(rst), .instr(instr), .Zero(Zero),
        .PCSrc(PCSrc), .ALUSrc(ALUSrc), .RegWrite(RegWrite), .MemToReg(MemToReg),
        .ALUCtrl(ALUCtrl), .loadPC(loadPC), .MemRead(MemRead), .MemWrite(MemWrite),
        .illegal(illegal), .instret(instret)
    );

    // Narrow counter instance so wrap-around is reached quickly.
    control_fsm #(.CNT_WIDTH(3)) dut_w (
        .clk(clk), .rst(rst), .instr(instr), .Zero(Zero),
        .PCSrc(w_PCSrc), .ALUSrc(w_ALUSrc), .RegWrite(w_RegWrite), .MemToReg(w_MemToReg),
        .ALUCtrl(w_ALUCtrl), .loadPC(w_loadPC), .MemRead(w_MemRead), .MemWrite(w_MemWrite),
        .illegal(w_illegal), .instret(instret_w)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic       ill;
        logic       writes;
        logic       lw;
        logic       sw;
        logic       beq;
        logic       alusrc;
        logic [3:0] alu;
    } dec_t;

    // ALU codes indexed by funct3 for the base (funct7 = 0) operations.
    logic [3:0] base_op [8] = '{4'b0010, 4'b1001, 4'b0111, 4'b1011,
                                4'b1101, 4'b1000, 4'b0001, 4'b0000};

    function automatic dec_t model_decode(input logic [31:0] w);
        dec_t       d;
        logic [6:0] op;
        logic [2:0] f3;
        logic [6:0] f7;
        op = w[6:0];
        f3 = w[14:12];
        f7 = w[31:25];
        d = '0;
        d.ill = 1'b1;
        if (op == 7'b0110011) begin
            if (f7 == 7'h00) begin
                d.ill = 1'b0; d.writes = 1'b1; d.alu = base_op[f3];
            end else if (f7 == 7'h20 && f3 == 3'd0) begin
                d.ill = 1'b0; d.writes = 1'b1; d.alu = 4'b0110;
            end else if (f7 == 7'h20 && f3 == 3'd5) begin
                d.ill = 1'b0; d.writes = 1'b1; d.alu = 4'b1010;
            end
        end else if (op == 7'b0010011) begin
            if (f3 == 3'd1 || f3 == 3'd5) begin
                if (f7 == 7'h00 || f7 == 7'h20) begin
                    d.ill = 1'b0; d.writes = 1'b1; d.alusrc = 1'b1;
                    d.alu = (f3 == 3'd1) ? 4'b1001 : (w[30] ? 4'b1010 : 4'b1000);
                end
            end else begin
                d.ill = 1'b0; d.writes = 1'b1; d.alusrc = 1'b1; d.alu = base_op[f3];
            end
        end else if (op == 7'b0000011 && f3 == 3'd2) begin
            d.ill = 1'b0; d.writes = 1'b1; d.lw = 1'b1; d.alusrc = 1'b1; d.alu = 4'b0010;
        end else if (op == 7'b0100011 && f3 == 3'd2) begin
            d.ill = 1'b0; d.sw = 1'b1; d.alusrc = 1'b1; d.alu = 4'b0010;
        end else if (op == 7'b1100011 && f3 == 3'd0) begin
            d.ill = 1'b0; d.beq = 1'b1; d.alu = 4'b0110;
        end
        return d;
    endfunction

    function automatic logic [11:0] outs();
        return {PCSrc, ALUSrc, RegWrite, MemToReg, ALUCtrl, loadPC, MemRead, MemWrite, illegal};
    endfunction

    function automatic logic [31:0] gen_instr();
        logic [31:0] w;
        int          k;
        int          r;
        w = $urandom;
        k = $urandom_range(0, 5);
        r = $urandom_range(0, 3);
        case (k)
            0: begin
                w[6:0] = 7'b0110011;
                if (r < 2) w[31:25] = 7'h00; else if (r == 2) w[31:25] = 7'h20;
            end
            1: begin
                w[6:0] = 7'b0010011;
                if (w[14:12] == 3'd1 || w[14:12] == 3'd5) begin
                    if (r < 2) w[31:25] = 7'h00; else if (r == 2) w[31:25] = 7'h20;
                end
            end
            2: begin w[6:0] = 7'b0000011; if (r != 0) w[14:12] = 3'b010; end
            3: begin w[6:0] = 7'b0100011; if (r != 0) w[14:12] = 3'b010; end
            4: begin w[6:0] = 7'b1100011; if (r != 0) w[14:12] = 3'b000; end
            default: ;
        endcase
        return w;
    endfunction

    // Runs one instruction from IF (entered at a negedge) back to the next IF.
    task automatic run_instr(input logic [31:0] iw, input logic z);
        dec_t        d;
        logic [11:0] exp;
        logic [11:0] mask;
        logic [11:0] got;
        d = model_decode(iw);
        mask = d.ill ? 12'b1011_0000_1111 : 12'hFFF;
        for (int c = 0; c < 5; c++) begin
            instr = (c == 0) ? iw : 32'($urandom);
            Zero  = (c == 2) ? z : 1'($urandom);
            #1;
            exp = {c == 4 && d.beq && z, c != 0 && d.alusrc, c == 4 && d.writes,
                   c != 0 && d.lw, (c != 0) ? d.alu : 4'b0000, c == 4,
                   c == 3 && d.lw, c == 3 && d.sw, c == 4 && d.ill};
            got = outs();
            checks++;
            if ((got & mask) !== (exp & mask)) begin
                errors++;
                $display("FAIL ctrl step%0d instr=%h z=%0d got=%b expected=%b", c, iw, z, got & mask, exp & mask);
            end
            @(negedge clk);
        end
        model_cnt++;
        checks++;
        if (instret !== model_cnt) begin
            errors++;
            $display("FAIL instret instr=%h got=%0d expected=%0d", iw, instret, model_cnt);
        end
        checks++;
        if (instret_w !== 3'(model_cnt)) begin
            errors++;
            $display("FAIL instret_wrap got=%0d expected=%0d", instret_w, 3'(model_cnt));
        end
    endtask

    task automatic test_reset();
        rst = 1'b0;
        instr = 32'($urandom);
        Zero = 1'b1;
        repeat (3) @(negedge clk);
        checks++;
        if (outs() !== 12'h000) begin
            errors++;
            $display("FAIL reset_ctrl got=%b expected=0", outs());
        end
        checks++;
        if (instret !== 32'd0 || instret_w !== 3'd0) begin
            errors++;
            $display("FAIL reset_instret got=%0d/%0d expected=0", instret, instret_w);
        end
        rst = 1'b1;
        model_cnt = 0;
    endtask

    task automatic test_directed();
        run_instr(32'h002081B3, 1'b0);
        run_instr(32'h00812283, 1'b0);
        run_instr(32'h00512223, 1'b1);
        run_instr(32'h00208463, 1'b1);
        run_instr(32'h00208463, 1'b0);
        run_instr(32'hFFFFFFFF, 1'b1);
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 300; i++) begin
            run_instr(gen_instr(), 1'($urandom));
        end
    endtask

    task automatic test_reset_mid();
        instr = 32'h002081B3;
        @(negedge clk);
        instr = 32'($urandom);
        @(negedge clk);
        // Now in EX of the add; assert reset between clock edges.
        #2;
        rst = 1'b0;
        #1;
        checks++;
        if (outs() !== 12'h000) begin
            errors++;
            $display("FAIL async_reset_ctrl got=%b expected=0", outs());
        end
        checks++;
        if (instret !== 32'd0 || instret_w !== 3'd0) begin
            errors++;
            $display("FAIL async_reset_instret got=%0d/%0d expected=0", instret, instret_w);
        end
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checks++;
            if (outs() !== 12'h000) begin
                errors++;
                $display("FAIL held_reset_ctrl cyc%0d got=%b expected=0", i, outs());
            end
        end
        rst = 1'b1;
        model_cnt = 0;
        run_instr(32'h002081B3, 1'b0);
        run_instr(32'h00812283, 1'b1);
    endtask

    initial begin
        @(negedge clk);
        test_reset();
        test_directed();
        test_back_to_back();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
